// File: rtl/pp_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | pp_dispatch: assigns whole path chunks round-robin to credited parsers.      |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module pp_dispatch #(
  parameter int NUM_PP            = 4,
  parameter int PP_BUFS           = 2,
  parameter int DATA_W            = 32,
  parameter int RCI_W             = 4,
  parameter int CHUNK_DEPTH_NBITS = 3,
  parameter int MAX_WORDS         = 1 << CHUNK_DEPTH_NBITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic [RCI_W-1:0]          in_rci,
  output logic                      in_ready,
  input  logic [NUM_PP-1:0]         path_parser_ready,
  output logic                      pp_valid,
  output logic [DATA_W-1:0]         pp_data,
  output logic                      pp_eop,
  output logic [$clog2(NUM_PP)-1:0] pp_id,
  output logic                      pp_meta_valid,
  output logic [RCI_W-1:0]          pp_meta_rci,
  output logic                      drop_pulse,
  output logic [15:0]               trunc_cnt
);

  localparam int ID_W   = $clog2(NUM_PP);
  localparam int CRED_W = $clog2(PP_BUFS + 1);
  localparam int WCNT_W = CHUNK_DEPTH_NBITS + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              state_q;
  logic [ID_W-1:0]     rr_q;
  logic [ID_W-1:0]     cur_id_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [WCNT_W-1:0]   wcnt_inc;
  logic                en_q;
  logic [CRED_W-1:0]   credit_q [NUM_PP];
  logic [NUM_PP-1:0]   rdy_hist_q;
  logic [NUM_PP-1:0]   rise;
  logic [NUM_PP-1:0]   has_cred;
  logic [NUM_PP-1:0]   dec;
  logic [ID_W-1:0]     sel;
  logic                accept;
  logic                sop_dispatch;

  assign rise         = path_parser_ready & ~rdy_hist_q;
  assign in_ready     = en_q && ((state_q != S_IDLE) || (|has_cred));
  assign accept       = in_valid && in_ready;
  assign sop_dispatch = accept && (state_q == S_IDLE) && in_sop;
  assign wcnt_inc     = wcnt_q + WCNT_W'(1);

  // First credited parser after the last one served.
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    sel   = rr_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_PP; k++) begin
      idx = ID_W'((int'(rr_q) + k) % NUM_PP);
      if (!found && has_cred[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_hist_q <= '0;
    else        rdy_hist_q <= path_parser_ready;
  end

  for (genvar i = 0; i < NUM_PP; i++) begin : g_cred
    assign has_cred[i] = (credit_q[i] != '0);
    assign dec[i]      = sop_dispatch && (sel == ID_W'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        credit_q[i] <= CRED_W'(PP_BUFS);
      end else if (rise[i] && !dec[i]) begin
        if (credit_q[i] != CRED_W'(PP_BUFS)) credit_q[i] <= credit_q[i] + CRED_W'(1);
      end else if (dec[i] && !rise[i]) begin
        credit_q[i] <= credit_q[i] - CRED_W'(1);
      end
    end

`ifndef SYNTHESIS
    a_credit_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(rise[i] && !dec[i] && (credit_q[i] == CRED_W'(PP_BUFS))));
    a_credit_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(dec[i] && (credit_q[i] == '0)));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_q          <= '0;
      cur_id_q      <= '0;
      wcnt_q        <= '0;
      en_q          <= 1'b0;
      pp_valid      <= 1'b0;
      pp_data       <= '0;
      pp_eop        <= 1'b0;
      pp_id         <= '0;
      pp_meta_valid <= 1'b0;
      pp_meta_rci   <= '0;
      drop_pulse    <= 1'b0;
      trunc_cnt     <= '0;
    end else begin
      en_q          <= 1'b1;
      pp_valid      <= 1'b0;
      pp_eop        <= 1'b0;
      pp_meta_valid <= 1'b0;
      drop_pulse    <= 1'b0;
      if (accept) begin
        case (state_q)
          S_IDLE: begin
            if (in_sop) begin
              cur_id_q      <= sel;
              rr_q          <= sel;
              pp_valid      <= 1'b1;
              pp_data       <= in_data;
              pp_id         <= sel;
              pp_eop        <= in_eop;
              pp_meta_valid <= 1'b1;
              pp_meta_rci   <= in_rci;
              wcnt_q        <= WCNT_W'(1);
              state_q       <= in_eop ? S_IDLE : S_XFER;
            end else begin
              drop_pulse <= 1'b1;
            end
          end
          S_XFER: begin
            pp_valid <= 1'b1;
            pp_data  <= in_data;
            pp_id    <= cur_id_q;
            wcnt_q   <= wcnt_inc;
            // A new sop closes the open chunk; the new chunk itself is discarded.
            if (in_sop) begin
              pp_eop  <= 1'b1;
              state_q <= in_eop ? S_IDLE : S_DROP;
              if (trunc_cnt != 16'hFFFF) trunc_cnt <= trunc_cnt + 16'd1;
            end else if (in_eop) begin
              pp_eop  <= 1'b1;
              state_q <= S_IDLE;
            end else if (wcnt_inc == WCNT_W'(MAX_WORDS)) begin
              pp_eop  <= 1'b1;
              state_q <= S_DROP;
              if (trunc_cnt != 16'hFFFF) trunc_cnt <= trunc_cnt + 16'd1;
            end
          end
          S_DROP: begin
            drop_pulse <= 1'b1;
            if (in_eop) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pp_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for pp_dispatch: vector table plus scoreboarded multi-cycle sequences.
module tb_pp_dispatch;
  localparam int DW   = 32;
  localparam int RW   = 4;
  localparam int NB   = 3;
  localparam int MAXW = 1 << NB;
  localparam int NPP  = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic [DW-1:0]  in_data = '0;
  logic           in_sop = 1'b0;
  logic           in_eop = 1'b0;
  logic [RW-1:0]  in_rci = '0;
  logic           in_ready;
  logic [NPP-1:0] path_parser_ready = '0;
  logic           pp_valid;
  logic [DW-1:0]  pp_data;
  logic           pp_eop;
  logic [1:0]     pp_id;
  logic           pp_meta_valid;
  logic [RW-1:0]  pp_meta_rci;
  logic           drop_pulse;
  logic [15:0]    trunc_cnt;

  pp_dispatch #(
    .NUM_PP(NPP), .PP_BUFS(2), .DATA_W(DW), .RCI_W(RW), .CHUNK_DEPTH_NBITS(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .in_rci(in_rci), .in_ready(in_ready), .path_parser_ready(path_parser_ready),
    .pp_valid(pp_valid), .pp_data(pp_data), .pp_eop(pp_eop), .pp_id(pp_id),
    .pp_meta_valid(pp_meta_valid), .pp_meta_rci(pp_meta_rci),
    .drop_pulse(drop_pulse), .trunc_cnt(trunc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
    logic [RW-1:0] rci;
    logic          emit;
    logic [1:0]    id;
    logic          xeop;
    logic          meta;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          eop;
    logic [1:0]    id;
    logic          meta;
    logic [RW-1:0] rci;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[8];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   drop_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint unsigned act,
                     input longint unsigned exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Output monitor: every emitted beat must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   ok;
    if (rst_n) begin
      if (drop_pulse) drop_cnt++;
      if (pp_valid) begin
        if (sbq.size() == 0) begin
          chk(1'b0, "unexpected_beat", {pp_id, pp_eop, pp_data}, 0);
        end else begin
          e  = sbq.pop_front();
          ok = (pp_data == e.data) && (pp_eop == e.eop) && (pp_id == e.id) &&
               (pp_meta_valid == e.meta) && (!e.meta || pp_meta_rci == e.rci) &&
               (cyc == e.cyc);
          chk(ok, "beat",
              {cyc[11:0], pp_meta_rci, pp_id, pp_eop, pp_meta_valid, pp_data},
              {e.cyc[11:0], e.rci, e.id, e.eop, e.meta, e.data});
        end
      end else if (pp_meta_valid) begin
        chk(1'b0, "meta_without_valid", 1, 0);
      end
    end
  end

  function automatic vec_t mk(input bit sop, eop, input logic [DW-1:0] d,
                              input logic [RW-1:0] r, input bit emit,
                              input logic [1:0] id, input bit xeop, input bit meta);
    vec_t v;
    v = '{sop, eop, d, r, emit, id, xeop, meta};
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input vec_t v, input bit need_rdy);
    int waitc;
    waitc    = 0;
    in_valid = 1'b1;
    in_sop   = v.sop;
    in_eop   = v.eop;
    in_data  = v.data;
    in_rci   = v.rci;
    if (need_rdy) chk(in_ready == 1'b1, "in_ready", in_ready, 1);
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!in_ready) begin
      chk(1'b0, "ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (v.emit) sbq.push_back('{v.data, v.xeop, v.id, v.meta, v.rci, cyc + 1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(sbq.size() == 0, "drain", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    path_parser_ready = '0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Eight single-beat chunks exhaust every credit; a ninth sop must stall.
  task automatic apply_table();
    for (int i = 0; i < 8; i++) send(tbl[i], 1'b1);
    drain();
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1;
    chk(in_ready == 1'b0, "ninth_blocked", in_ready, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int d0;
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 1'b1, DW'(32'hA000_0000 + i), RW'(i), 1'b1, 2'((i + 1) % 4), 1'b1, 1'b1};

    // Reset state, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk({in_ready, pp_valid, pp_eop, pp_meta_valid, drop_pulse} == 5'b0, "reset_flags",
        {in_ready, pp_valid, pp_eop, pp_meta_valid, drop_pulse}, 0);
    chk(trunc_cnt == 16'd0 && pp_id == 2'd0 && pp_data == '0, "reset_values",
        {trunc_cnt, pp_id}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 3-beat chunk with rci=5 goes to parser 1.
    send(mk(1, 0, 32'h1111_0001, 4'd5, 1, 2'd1, 0, 1), 1'b1);
    send(mk(0, 0, 32'h1111_0002, 4'd5, 1, 2'd1, 0, 0), 1'b1);
    send(mk(0, 1, 32'h1111_0003, 4'd5, 1, 2'd1, 1, 0), 1'b1);
    drain();

    // Table: round-robin 1,2,3,0,... then credit return on parser 2.
    do_reset();
    apply_table();
    path_parser_ready[2] = 1'b1;
    send(mk(1, 1, 32'h9999_0009, 4'd9, 1, 2'd2, 1, 1), 1'b0);
    drain();

    // Oversize chunk: MAXW beats forwarded, three dropped.
    do_reset();
    chk(trunc_cnt == 16'd0, "trunc_before", trunc_cnt, 0);
    d0 = drop_cnt;
    for (int i = 0; i < MAXW + 3; i++)
      send(mk(i == 0, i == MAXW + 2, DW'(32'hB000_0000 + i), 4'd3, i < MAXW, 2'd1,
              i == MAXW - 1, i == 0), 1'b1);
    drain();
    chk(drop_cnt - d0 == 3, "trunc_drops", drop_cnt - d0, 3);
    chk(trunc_cnt == 16'd1, "trunc_after", trunc_cnt, 1);
    send(mk(1, 1, 32'hC000_0001, 4'd1, 1, 2'd2, 1, 1), 1'b1);
    drain();

    // Orphan beat in IDLE.
    d0 = drop_cnt;
    send(mk(0, 0, 32'hDEAD_0000, 4'd0, 0, 2'd0, 0, 0), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk(drop_cnt - d0 == 1, "orphan_drop", drop_cnt - d0, 1);
    send(mk(1, 1, 32'hC000_0002, 4'd2, 1, 2'd3, 1, 1), 1'b1);
    drain();

    // Credit release and dispatch to the same parser in one cycle.
    do_reset();
    for (int i = 0; i < 4; i++)
      send(mk(1, 1, DW'(32'hE000_0000 + i), 4'd0, 1, 2'((i + 1) % 4), 1, 1), 1'b1);
    path_parser_ready[1] = 1'b1;
    send(mk(1, 1, 32'hE000_0010, 4'd7, 1, 2'd1, 1, 1), 1'b1);
    for (int i = 0; i < 4; i++)
      send(mk(1, 1, DW'(32'hE000_0020 + i), 4'd0, 1, 2'((i + 2) % 4), 1, 1), 1'b1);
    drain();
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1;
    chk(in_ready == 1'b0, "same_cycle_blocked", in_ready, 0);
    in_valid = 1'b0;

    // Reset asserted mid-chunk clears outputs without a clock edge.
    do_reset();
    send(mk(1, 0, 32'hF000_0001, 4'd4, 1, 2'd1, 0, 1), 1'b1);
    send(mk(0, 0, 32'hF000_0002, 4'd4, 0, 2'd1, 0, 0), 1'b1);
    chk(pp_valid == 1'b1, "pre_reset_valid", pp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk({in_ready, pp_valid, pp_eop, pp_meta_valid, drop_pulse} == 5'b0, "async_reset_flags",
        {in_ready, pp_valid, pp_eop, pp_meta_valid, drop_pulse}, 0);
    chk(pp_id == 2'd0 && pp_data == '0 && trunc_cnt == 16'd0, "async_reset_values",
        {pp_id, pp_data}, 0);
    sbq.delete();
    do_reset();
    apply_table();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(sbq.size() == 0, "final_queue", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
